// File: rtl/stream_arbiter.sv
// Round-robin arbiter that funnels N single-word stb/ack producer streams into one
// registered output channel, with a sticky watchdog flag for a stalled sink.
module stream_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*WIDTH-1:0]     input_in,
    input  logic [N-1:0]           input_in_stb,
    output logic [N-1:0]           input_in_ack,
    output logic [WIDTH-1:0]       output_out,
    output logic                   output_out_stb,
    input  logic                   output_out_ack,
    output logic [$clog2(N)-1:0]   output_grant,
    output logic                   exception
);

    localparam int GW = $clog2(N);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_SET = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_ptr;
    logic [N-1:0]        r_ack;
    logic [WIDTH-1:0]    r_out;
    logic                r_stb;
    logic [GW-1:0]       r_grant;
    logic [CW-1:0]       r_wdog;
    logic                r_exc;

    state_t              w_state;
    logic [GW-1:0]       w_ptr;
    logic [N-1:0]        w_ack;
    logic [WIDTH-1:0]    w_out;
    logic                w_stb;
    logic [GW-1:0]       w_grant;
    logic [CW-1:0]       w_wdog;
    logic                w_exc;

    logic [WIDTH-1:0]    w_in [N];
    logic [2*N-1:0]      w_shift;
    logic [N-1:0]        w_rot;
    logic                w_found;
    logic [GW-1:0]       w_off;
    logic [GW:0]         w_sum;
    logic [GW-1:0]       w_sel;
    logic [GW-1:0]       w_ptr_after;
    logic [CW-1:0]       w_wdog_inc;

    genvar gk;
    generate
        for (gk = 0; gk < N; gk++) begin : g_unpack
            assign w_in[gk] = input_in[gk*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate requests so that bit 0 is the stream at the round-robin pointer
    assign w_shift = {input_in_stb, input_in_stb} >> r_ptr;
    assign w_rot   = w_shift[N-1:0];

    // Lowest set bit of the rotated vector wins; scanning downward lets it overwrite
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_off   = w_rot[i] ? GW'(i) : w_off;
            w_found = w_found | w_rot[i];
        end
    end

    assign w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sel       = (w_sum >= (GW+1)'(N)) ? GW'(w_sum - (GW+1)'(N)) : w_sum[GW-1:0];
    assign w_ptr_after = (r_grant == GW'(N - 1)) ? '0 : (r_grant + GW'(1));
    assign w_wdog_inc  = (r_wdog == TO_MAX) ? r_wdog : (r_wdog + CW'(1));

    // Next-state and next-output logic for the grant/ack/send sequence
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_ack   = r_ack;
        w_out   = r_out;
        w_stb   = r_stb;
        w_grant = r_grant;
        w_wdog  = r_wdog;
        w_exc   = r_exc;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ack   = {{(N-1){1'b0}}, 1'b1} << w_sel;
                    w_grant = w_sel;
                    w_state = S_ACK;
                end else begin
                    w_ack   = '0;
                end
            end
            S_ACK: begin
                w_out   = w_in[r_grant];
                w_ack   = '0;
                w_stb   = 1'b1;
                w_wdog  = '0;
                w_state = S_SEND;
            end
            S_SEND: begin
                if (output_out_ack) begin
                    w_stb   = 1'b0;
                    w_ptr   = w_ptr_after;
                    w_state = S_IDLE;
                end else if (TIMEOUT > 0) begin
                    // Flag raised on the same edge the counter lands on TIMEOUT-1
                    w_wdog = w_wdog_inc;
                    w_exc  = r_exc | (w_wdog_inc >= TO_SET);
                end else begin
                    w_wdog = r_wdog;
                end
            end
            default: begin
                w_ack   = '0;
                w_stb   = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_ack   <= '0;
            r_out   <= '0;
            r_stb   <= 1'b0;
            r_grant <= '0;
            r_wdog  <= '0;
            r_exc   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_ack   <= w_ack;
            r_out   <= w_out;
            r_stb   <= w_stb;
            r_grant <= w_grant;
            r_wdog  <= w_wdog;
            r_exc   <= w_exc;
        end
    end

    assign input_in_ack   = r_ack;
    assign output_out     = r_out;
    assign output_out_stb = r_stb;
    assign output_grant   = r_grant;
    assign exception      = r_exc;

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: request-pattern table plus corner-case
// sequences, with output words checked against a scoreboard queue.
module tb_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_stb;
    logic [N-1:0]     in_ack;
    logic [W-1:0]     out_data;
    logic             out_stb;
    logic             out_ack;
    logic [1:0]       grant;
    logic             exc;

    stream_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_in       (in_data),
        .input_in_stb   (in_stb),
        .input_in_ack   (in_ack),
        .output_out     (out_data),
        .output_out_stb (out_stb),
        .output_out_ack (out_ack),
        .output_grant   (grant),
        .exception      (exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   grant;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        int         cnt;
        logic [7:0] ord;
    } vec_t;

    exp_t       sbq[$];
    exp_t       e;
    vec_t       vecs[7];
    logic [7:0] ord;
    logic [1:0] g;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [N-1:0] oneshot;
    int         stop_after;
    int         n_xfer;
    bit         rr_check;
    int         cyc = 0;
    int         last_hs = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] vdata(input int v, input int k);
        return 32'hC0DE0000 + 32'(v * 256 + k);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every output handshake pops one expected word
    always @(negedge clk) begin
        if (!rst && out_stb && out_ack) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", out_data);
            end else begin
                e = sbq.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_grant", 64'(grant), 64'(e.grant));
                if (rr_check && last_hs >= 0) chk("rr_period", 64'(cyc - last_hs), 64'd3);
                last_hs = cyc;
            end
        end
    end

    // Producers: a stream that was acked on this edge retires its word
    task automatic step();
        logic [N-1:0] acked;
        acked = in_ack & in_stb;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acked[k]) begin
                n_xfer++;
                if (oneshot[k]) in_stb[k] = 1'b0;
            end
        end
        if (stop_after > 0 && n_xfer >= stop_after) in_stb = '0;
    endtask

    task automatic req(input int k, input logic [31:0] d, input bit os);
        in_data[k*W +: W] = d;
        in_stb[k]  = 1'b1;
        oneshot[k] = os;
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] gr);
        sbq.push_back('{data: d, grant: gr});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        sbq.delete();
        last_hs = -1;
        rst = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int b = 0;
        while (sbq.size() != 0 && b < 60) begin
            step();
            b++;
        end
        chk(nm, 64'(sbq.size()), 64'd0);
    endtask

    task automatic wait_stb(input string nm);
        int b = 0;
        while (!out_stb && b < 20) begin
            step();
            b++;
        end
        chk(nm, 64'(out_stb), 64'd1);
    endtask

    initial begin
        // ord packs the expected grant order, first grant in bits [1:0]
        vecs[0] = '{req: 4'b1000, cnt: 1, ord: 8'h03};
        vecs[1] = '{req: 4'b1001, cnt: 2, ord: 8'h0C};
        vecs[2] = '{req: 4'b0110, cnt: 2, ord: 8'h09};
        vecs[3] = '{req: 4'b0111, cnt: 3, ord: 8'h24};
        vecs[4] = '{req: 4'b1111, cnt: 4, ord: 8'h93};
        vecs[5] = '{req: 4'b0100, cnt: 1, ord: 8'h02};
        vecs[6] = '{req: 4'b1010, cnt: 2, ord: 8'h07};

        rst = 1'b1; in_data = '0; in_stb = '0; out_ack = 1'b0;
        oneshot = '0; stop_after = 0; n_xfer = 0; rr_check = 1'b0;
        step();
        step();
        chk("rst_ack",   64'(in_ack),   64'd0);
        chk("rst_stb",   64'(out_stb),  64'd0);
        chk("rst_out",   64'(out_data), 64'd0);
        chk("rst_grant", 64'(grant),    64'd0);
        chk("rst_exc",   64'(exc),      64'd0);
        rst = 1'b0;

        // Single request on stream 2, sink always ready
        out_ack = 1'b1;
        req(2, 32'h12345678, 1'b1);
        push(32'h12345678, 2'd2);
        chk("single_no_ack_yet", 64'(in_ack), 64'd0);
        step();
        chk("single_ack",       64'(in_ack),  64'h4);
        chk("single_grant",     64'(grant),   64'd2);
        chk("single_stb_early", 64'(out_stb), 64'd0);
        step();
        chk("single_ack_drop", 64'(in_ack),   64'd0);
        chk("single_stb",      64'(out_stb),  64'd1);
        chk("single_data",     64'(out_data), 64'h12345678);
        step();
        chk("single_stb_end", 64'(out_stb), 64'd0);

        // Request-pattern table; pointer carries over between rows
        for (int v = 0; v < 7; v++) begin
            out_ack = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (vecs[v].req[k]) req(k, vdata(v, k), 1'b1);
            end
            ord = vecs[v].ord;
            for (int i = 0; i < vecs[v].cnt; i++) begin
                g = ord[2*i +: 2];
                push(vdata(v, int'(g)), g);
            end
            wait_empty($sformatf("vec%0d_drain", v));
        end

        // Continuous round-robin from pointer 0, one word every 3 cycles
        do_reset();
        n_xfer = 0; stop_after = 5; rr_check = 1'b1;
        for (int k = 0; k < N; k++) req(k, 32'hA0 + 32'(k), 1'b0);
        push(32'hA0, 2'd0); push(32'hA1, 2'd1); push(32'hA2, 2'd2);
        push(32'hA3, 2'd3); push(32'hA0, 2'd0);
        wait_empty("rr_drain");
        rr_check = 1'b0; stop_after = 0;

        // Backpressure: stall 10 cycles, then rotation continues after stream 1
        out_ack = 1'b0;
        req(1, 32'hB1, 1'b1);
        push(32'hB1, 2'd1);
        wait_stb("bp_stb");
        req(0, 32'hB0, 1'b1);
        req(2, 32'hB2, 1'b1);
        push(32'hB2, 2'd2);
        push(32'hB0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", 64'({out_stb, out_data, in_ack, exc}), 64'({1'b1, 32'hB1, 4'b0000, 1'b0}));
            step();
        end
        out_ack = 1'b1;
        wait_empty("bp_drain");

        // Watchdog: exception from the 16th stalled SEND cycle onward
        out_ack = 1'b0;
        req(3, 32'hD3, 1'b1);
        push(32'hD3, 2'd3);
        wait_stb("wd_stb");
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("wdog_c%0d", k), 64'({exc, out_stb}), 64'({(k >= 16) ? 1'b1 : 1'b0, 1'b1}));
            step();
        end
        do_reset();
        chk("wd_rst_exc", 64'(exc),     64'd0);
        chk("wd_rst_stb", 64'(out_stb), 64'd0);

        // Reset while a word waits in SEND: word discarded, pointer back to 0
        out_ack = 1'b0;
        req(3, 32'hE3, 1'b1);
        push(32'hE3, 2'd3);
        wait_stb("ms_stb");
        step();
        do_reset();
        chk("ms_stb", 64'(out_stb), 64'd0);
        chk("ms_ack", 64'(in_ack),  64'd0);
        req(1, 32'hE1, 1'b1);
        req(2, 32'hE2, 1'b1);
        push(32'hE1, 2'd1);
        push(32'hE2, 2'd2);
        out_ack = 1'b1;
        wait_empty("ms_drain");

        step();
        step();
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit stb/ack output channel (e.g. rs232 tx, eth tx) among N producer processes inside user_design.
- Each granted requester transfers exactly one word, then the grant rotates.
- A watchdog raises a sticky exception when the shared sink stalls. That exception is ORed into the top-level exception with the other process exceptions.

Parameters:
- N, 4, number of requester streams (2..8).
- WIDTH, 32, data word width.
- TIMEOUT, 1000000, cycles in SEND without output ack before exception is set; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- input_in  input  N*WIDTH  requester data, stream k on bits [k*WIDTH +: WIDTH].
- input_in_stb  input  N  per-stream strobe; producer holds data stable while stb=1 until ack.
- input_in_ack  output  N  per-stream acknowledge; registered, one-hot or zero.
- output_out  output  WIDTH  arbitrated data word; registered.
- output_out_stb  output  1  output strobe; registered.
- output_out_ack  input  1  sink acknowledge.
- output_grant  output  clog2(N)  index of the most recently granted stream; registered.
- exception  output  1  sticky watchdog flag.

Behaviour:
- Reset is synchronous and active-high. Clock is clk, reset is rst.
- Reset values:
  - input_in_ack=0, output_out_stb=0, output_out=0, output_grant=0, exception=0.
  - Round-robin pointer ptr=0, watchdog counter=0, state=IDLE.
- Transfer rule, both sides: a word moves on a cycle where stb=1 and ack=1.
- State machine:
  - IDLE:
    - Search input_in_stb starting at index ptr, wrapping modulo N; the first set bit is g.
    - If one is found: input_in_ack[g]<=1, output_grant<=g, state<=ACK.
    - If none is found: stay in IDLE, all acks 0.
  - ACK:
    - input_in_ack[g] is high this cycle, so the transfer completes.
    - output_out<=input_in[g], input_in_ack<=0, output_out_stb<=1, watchdog<=0, state<=SEND.
  - SEND:
    - output_out_stb held at 1 and output_out held stable.
    - If output_out_ack=1: output_out_stb<=0, ptr<=(g+1) mod N, state<=IDLE.
    - Otherwise the watchdog increments, saturating at TIMEOUT.
- Latency: a word seen on input_in_stb in IDLE appears on output_out_stb 2 cycles later. Minimum period is 3 cycles per word when the sink acks immediately.
- Fairness: after g is served, g has the lowest priority. Every continuously requesting stream is served within N grants.
- Simultaneous requests: all evaluated in the same IDLE cycle; the pointer order decides the winner.
- A requester dropping stb in IDLE before it is granted is legal and is simply not selected. Dropping stb while ack is pending violates the protocol; behaviour is unspecified.
- output_out_ack while output_out_stb=0 is ignored.
- Watchdog (TIMEOUT>0):
  - exception<=1 when the counter reaches TIMEOUT-1 while still in SEND with no ack.
  - exception stays set until rst. The transfer keeps waiting and is not dropped.
- Reset mid-operation: any word in ACK or SEND is discarded, with no output stb afterwards. ptr returns to 0 and state to IDLE on the next cycle.
- N=1 is not supported (minimum 2); output_grant width is clog2(N).

Test Plan:
- Single request:
  - Stimulus: stream 2 presents 0x12345678 with stb=1; sink ack tied high.
  - Required: input_in_ack[2]=1 for exactly one cycle, 1 cycle after stb is seen. output_out=0x12345678 with output_out_stb=1 two cycles after stb is seen, for one cycle. output_grant=2.
- Round-robin:
  - Stimulus: streams 0..3 all request continuously with data 0xA0..0xA3; sink always acks.
  - Required: output sequence 0xA0,0xA1,0xA2,0xA3,0xA0, one word every 3 cycles.
- Pointer wrap:
  - Stimulus: after stream 3 is served, streams 0 and 3 both request.
  - Required: stream 0 is granted first, then stream 3.
- Backpressure:
  - Stimulus: sink holds ack=0 for 10 cycles with TIMEOUT=16.
  - Required: output_out_stb and the data stay stable; no input ack; exception stays 0. After ack, the next grant goes to the next index.
- Watchdog:
  - Stimulus: TIMEOUT=16, sink never acks.
  - Required: exception=1 on the 16th SEND cycle and stays 1. output_out_stb stays 1. After rst, exception=0.
- Reset mid-SEND:
  - Stimulus: assert rst for 1 cycle while output_out_stb=1.
  - Required: next cycle output_out_stb=0 and all acks 0. With streams 1 and 2 requesting, the next grant is stream 1 (ptr=0).
